// File: rtl/cache_rd_arbiter.sv
// rtl/cache_rd_arbiter.sv - ICache/DCache arbiter for the single bridge read port, with a burst watchdog.
// Optional ARB_DCACHE_PRIO_EN: m1 wins every tie (fixed priority); default is round-robin.
module cache_rd_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        m0_rd_req,
    input  logic [2:0]  m0_rd_type,
    input  logic [31:0] m0_rd_addr,
    output logic        m0_rd_rdy,
    output logic        m0_ret_valid,
    output logic        m0_ret_last,
    output logic [31:0] m0_ret_data,
    input  logic        m1_rd_req,
    input  logic [2:0]  m1_rd_type,
    input  logic [31:0] m1_rd_addr,
    output logic        m1_rd_rdy,
    output logic        m1_ret_valid,
    output logic        m1_ret_last,
    output logic [31:0] m1_ret_data,
    output logic        s_rd_req,
    output logic [2:0]  s_rd_type,
    output logic [31:0] s_rd_addr,
    input  logic        s_rd_rdy,
    input  logic        s_ret_valid,
    input  logic        s_ret_last,
    input  logic [31:0] s_ret_data,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT - 1);

    logic [0:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            rr_last_q, rr_last_d;
    logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;

    logic win;
    logic req_any;
    logic in_idle;
    logic in_resp;

    always_comb begin
        win = 1'b0;
        if (m0_rd_req && m1_rd_req) begin
`ifdef ARB_DCACHE_PRIO_EN
            win = 1'b1;
`else
            win = ~rr_last_q;
`endif
        end else if (m1_rd_req) begin
            win = 1'b1;
        end
    end

    // Outputs are gated by aresetn so they read 0 for the whole reset window, not just after the edge.
    always_comb begin
        req_any = m0_rd_req | m1_rd_req;
        in_idle = aresetn && (state_q == S_IDLE);
        in_resp = aresetn && (state_q == S_RESP);

        s_rd_req  = in_idle & req_any;
        s_rd_addr = 32'd0;
        s_rd_type = 3'd0;
        if (s_rd_req) begin
            s_rd_addr = win ? m1_rd_addr : m0_rd_addr;
            s_rd_type = win ? m1_rd_type : m0_rd_type;
        end
        m0_rd_rdy = s_rd_req & s_rd_rdy & ~win;
        m1_rd_rdy = s_rd_req & s_rd_rdy &  win;

        m0_ret_valid = in_resp & ~owner_q & s_ret_valid;
        m0_ret_last  = in_resp & ~owner_q & s_ret_last;
        m0_ret_data  = (in_resp && !owner_q) ? s_ret_data : 32'd0;
        m1_ret_valid = in_resp &  owner_q & s_ret_valid;
        m1_ret_last  = in_resp &  owner_q & s_ret_last;
        m1_ret_data  = (in_resp && owner_q) ? s_ret_data : 32'd0;

        busy        = in_resp;
        err_timeout = err_q;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        wd_cnt_d  = wd_cnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_any && s_rd_rdy) begin
                    owner_d   = win;
                    rr_last_d = win;
                    wd_cnt_d  = '0;
                    state_d   = S_RESP;
                end
            end
            default: begin
                if (s_ret_valid) begin
                    wd_cnt_d = '0;
                    if (s_ret_last) begin
                        state_d = S_IDLE;
                    end
                end else if (wd_cnt_q == WD_LIMIT) begin
                    err_d    = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b0;
            wd_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            wd_cnt_q  <= wd_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb/tb_cache_rd_arbiter.sv - directed self-checking bench for cache_rd_arbiter (TIMEOUT=16).
module tb_cache_rd_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        m0_rd_req, m1_rd_req;
    logic [2:0]  m0_rd_type, m1_rd_type;
    logic [31:0] m0_rd_addr, m1_rd_addr;
    logic        m0_rd_rdy, m0_ret_valid, m0_ret_last;
    logic [31:0] m0_ret_data;
    logic        m1_rd_rdy, m1_ret_valid, m1_ret_last;
    logic [31:0] m1_ret_data;
    logic        s_rd_req;
    logic [2:0]  s_rd_type;
    logic [31:0] s_rd_addr;
    logic        s_rd_rdy, s_ret_valid, s_ret_last;
    logic [31:0] s_ret_data;
    logic        busy, err_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cache_rd_arbiter #(.TIMEOUT(16), .TO_W(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m0_rd_req(m0_rd_req), .m0_rd_type(m0_rd_type), .m0_rd_addr(m0_rd_addr),
        .m0_rd_rdy(m0_rd_rdy), .m0_ret_valid(m0_ret_valid), .m0_ret_last(m0_ret_last),
        .m0_ret_data(m0_ret_data),
        .m1_rd_req(m1_rd_req), .m1_rd_type(m1_rd_type), .m1_rd_addr(m1_rd_addr),
        .m1_rd_rdy(m1_rd_rdy), .m1_ret_valid(m1_ret_valid), .m1_ret_last(m1_ret_last),
        .m1_ret_data(m1_ret_data),
        .s_rd_req(s_rd_req), .s_rd_type(s_rd_type), .s_rd_addr(s_rd_addr),
        .s_rd_rdy(s_rd_rdy), .s_ret_valid(s_ret_valid), .s_ret_last(s_ret_last),
        .s_ret_data(s_ret_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 aclk = ~aclk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_rd_req = 0; m0_rd_type = 0; m0_rd_addr = 0;
        m1_rd_req = 0; m1_rd_type = 0; m1_rd_addr = 0;
        s_rd_rdy = 0; s_ret_valid = 0; s_ret_last = 0; s_ret_data = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        aresetn = 0;
        tick();
        tick();
        aresetn = 1;
    endtask

    task automatic serve_burst(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            s_ret_valid = 1; s_ret_data = base + 32'(i); s_ret_last = (i == 3);
            tick();
        end
        s_ret_valid = 0; s_ret_last = 0; s_ret_data = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        aresetn = 0;
        m0_rd_req = 1; m0_rd_addr = 32'h1234; s_rd_rdy = 1; s_ret_valid = 1; s_ret_last = 1;
        s_ret_data = 32'hdead;
        tick();
        total_cnt++;
        if ({s_rd_req, m0_rd_rdy, m1_rd_rdy, busy, err_timeout} !== 5'b0)
            $display("FAIL reset_ctrl got %b exp 00000", {s_rd_req, m0_rd_rdy, m1_rd_rdy, busy, err_timeout});
        else pass_cnt++;
        total_cnt++;
        if ({m0_ret_valid, m0_ret_last, m1_ret_valid, m1_ret_last, m0_ret_data, s_rd_addr} !== 68'd0)
            $display("FAIL reset_data got %h/%h exp 0", m0_ret_data, s_rd_addr);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_single_burst();
        do_reset();
        m0_rd_req = 1; m0_rd_addr = 32'h1c000000; m0_rd_type = 3'b110; s_rd_rdy = 1;
        #1;
        total_cnt++;
        if ({s_rd_req, m0_rd_rdy, m1_rd_rdy} !== 3'b110 || s_rd_addr !== 32'h1c000000 || s_rd_type !== 3'b110)
            $display("FAIL t1_grant got req/rdy0/rdy1=%b addr=%h type=%b exp 110 1c000000 110",
                     {s_rd_req, m0_rd_rdy, m1_rd_rdy}, s_rd_addr, s_rd_type);
        else pass_cnt++;
        tick();
        m0_rd_req = 0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL t1_busy got %b exp 1", busy); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            s_ret_valid = 1; s_ret_data = 32'hA0 + 32'(i); s_ret_last = (i == 3);
            #1;
            total_cnt++;
            if (m0_ret_valid !== 1'b1 || m0_ret_data !== 32'hA0 + 32'(i) || m0_ret_last !== (i == 3) || m1_ret_valid !== 1'b0)
                $display("FAIL t1_beat%0d got v=%b d=%h l=%b m1v=%b exp 1 %h %b 0",
                         i, m0_ret_valid, m0_ret_data, m0_ret_last, m1_ret_valid, 32'hA0 + 32'(i), (i == 3));
            else pass_cnt++;
            tick();
        end
        s_ret_valid = 0; s_ret_last = 0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL t1_busy_fall got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_win;
`ifdef ARB_DCACHE_PRIO_EN
        exp_win = 3'b111;
`else
        exp_win = 3'b101;
`endif
        do_reset();
        m0_rd_req = 1; m0_rd_addr = 32'h1000; m0_rd_type = 3'b110;
        m1_rd_req = 1; m1_rd_addr = 32'h2000; m1_rd_type = 3'b110;
        s_rd_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++;
            if (s_rd_addr !== (exp_win[k] ? 32'h2000 : 32'h1000) || m1_rd_rdy !== exp_win[k] || m0_rd_rdy !== !exp_win[k])
                $display("FAIL rr_grant%0d got addr=%h rdy0=%b rdy1=%b exp m%0d",
                         k, s_rd_addr, m0_rd_rdy, m1_rd_rdy, exp_win[k]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (s_rd_req !== 1'b0) $display("FAIL rr_resp_req%0d got %b exp 0", k, s_rd_req); else pass_cnt++;
            serve_burst(32'h100 * 32'(k));
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m0_rd_req = 1; m0_rd_addr = 32'h1000; s_rd_rdy = 1;
        tick();
        m0_rd_req = 0;
        m1_rd_req = 1; m1_rd_addr = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            s_ret_valid = 1; s_ret_data = 32'hB0 + 32'(i); s_ret_last = (i == 3);
            #1;
            total_cnt++;
            if (s_rd_req !== 1'b0 || m1_rd_rdy !== 1'b0)
                $display("FAIL b2b_block%0d got req=%b rdy1=%b exp 0 0", i, s_rd_req, m1_rd_rdy);
            else pass_cnt++;
            tick();
        end
        s_ret_valid = 0; s_ret_last = 0;
        total_cnt++;
        if (m1_rd_rdy !== 1'b1 || s_rd_addr !== 32'h2000)
            $display("FAIL b2b_grant got rdy1=%b addr=%h exp 1 00002000", m1_rd_rdy, s_rd_addr);
        else pass_cnt++;
        tick();
        m1_rd_req = 0;
        s_ret_valid = 1; s_ret_data = 32'hC0; s_ret_last = 0;
        #1;
        total_cnt++;
        if (m1_ret_valid !== 1'b1 || m1_ret_data !== 32'hC0 || m0_ret_valid !== 1'b0 || m0_ret_data !== 32'h0)
            $display("FAIL b2b_route got m1v=%b m1d=%h m0v=%b m0d=%h exp 1 c0 0 0",
                     m1_ret_valid, m1_ret_data, m0_ret_valid, m0_ret_data);
        else pass_cnt++;
        s_ret_valid = 0;
        tick();
        serve_burst(32'hC1);
    endtask

    task automatic test_timeout();
        do_reset();
        m0_rd_req = 1; m0_rd_addr = 32'h3000; s_rd_rdy = 1;
        tick();
        m0_rd_req = 0;
        for (int i = 0; i < 15; i++) tick();
        total_cnt++;
        if (busy !== 1'b1 || err_timeout !== 1'b0)
            $display("FAIL to_before got busy=%b err=%b exp 1 0", busy, err_timeout);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || err_timeout !== 1'b1)
            $display("FAIL to_abort got busy=%b err=%b exp 0 1", busy, err_timeout);
        else pass_cnt++;
        s_ret_valid = 1; s_ret_last = 1; s_ret_data = 32'hEE;
        #1;
        total_cnt++;
        if (m0_ret_valid !== 1'b0 || m1_ret_valid !== 1'b0)
            $display("FAIL to_stray got m0v=%b m1v=%b exp 0 0", m0_ret_valid, m1_ret_valid);
        else pass_cnt++;
        tick();
        s_ret_valid = 0; s_ret_last = 0;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || err_timeout !== 1'b1)
            $display("FAIL to_sticky got busy=%b err=%b exp 0 1", busy, err_timeout);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        m0_rd_req = 1; m0_rd_addr = 32'h4000; s_rd_rdy = 1;
        tick();
        m0_rd_req = 0;
        for (int i = 0; i < 2; i++) begin
            s_ret_valid = 1; s_ret_data = 32'hD0 + 32'(i);
            tick();
        end
        m1_rd_req = 1; m1_rd_addr = 32'h5000;
        aresetn = 0;
        #1;
        total_cnt++;
        if ({m0_ret_valid, m0_ret_last, busy, s_rd_req, m1_rd_rdy, m0_rd_rdy} !== 6'b0 || m0_ret_data !== 32'h0 || s_rd_addr !== 32'h0)
            $display("FAIL rst_mid got ctl=%b d=%h a=%h exp 0", {m0_ret_valid, m0_ret_last, busy, s_rd_req, m1_rd_rdy, m0_rd_rdy},
                     m0_ret_data, s_rd_addr);
        else pass_cnt++;
        tick();
        clear_inputs();
        aresetn = 1;
        m0_rd_req = 1; m0_rd_addr = 32'h6000; s_rd_rdy = 1;
        #1;
        total_cnt++;
        if (m0_rd_rdy !== 1'b1 || s_rd_addr !== 32'h6000 || err_timeout !== 1'b0)
            $display("FAIL rst_regrant got rdy0=%b addr=%h err=%b exp 1 00006000 0", m0_rd_rdy, s_rd_addr, err_timeout);
        else pass_cnt++;
        tick();
        m0_rd_req = 0;
        for (int i = 0; i < 4; i++) begin
            s_ret_valid = 1; s_ret_data = 32'hE0 + 32'(i); s_ret_last = (i == 3);
            #1;
            total_cnt++;
            if (m0_ret_valid !== 1'b1 || m0_ret_data !== 32'hE0 + 32'(i) || m0_ret_last !== (i == 3))
                $display("FAIL rst_beat%0d got v=%b d=%h l=%b exp 1 %h %b", i, m0_ret_valid, m0_ret_data, m0_ret_last,
                         32'hE0 + 32'(i), (i == 3));
            else pass_cnt++;
            tick();
        end
        s_ret_valid = 0; s_ret_last = 0;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_done got busy=%b exp 0", busy); else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        aresetn = 0;
        #2;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
